gpio_ctrl: RTL and testbench

Parametrised GPIO controller on the dbus peripheral port, GPIO_WIDTH pins wide.
Adds per-pin direction control, atomic set/clear of outputs, a 2-flop input synchroniser and edge-triggered interrupts with per-pin enable and polarity.
Selected by the dbus interconnect address decoder. Registered single-cycle-latency acknowledge.

---
 rtl/gpio_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_gpio_ctrl.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ctrl.sv
// gpio_ctrl: GPIO controller on the dbus peripheral port.
//
// Features: per-pin direction, atomic set/clear of outputs, an input
// synchroniser, and edge-triggered interrupts with per-pin enable and
// polarity. A bus access is taken on any posedge that sees req && gpio_sel_i.
// The acknowledge comes exactly one cycle later and lasts one cycle.
//
// Optional build macro: GPIO_DEBOUNCE_EN. When it is defined, a per-pin
// debounce filter sits after the synchroniser.
//
// Ports:
//   clk          system clock; all logic runs on posedge
//   rst_n        asynchronous active-low reset
//   dbus2gpio_i  bus request: req, wr, mask[3:0], addr, w_data
//   gpio2dbus_o  bus response: r_data, ack
//   gpio_sel_i   select from the interconnect address decoder
//   gpio_port_i  asynchronous pin inputs
//   gpio_port_o  pin output values (DATA_OUT)
//   gpio_oe_o    per-pin output enable (DIR, 1 = drive)
//   gpio_irq_o   level interrupt, OR of IRQ_STATUS & IRQ_EN

package dbus_pkg;
  typedef struct packed {
    logic        req;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] w_data;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [31:0] r_data;
    logic        ack;
  } type_peri2dbus_s;
endpackage

module gpio_ctrl
  import dbus_pkg::*;
#(
  parameter int GPIO_WIDTH      = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  type_dbus2peri_s       dbus2gpio_i,
  output type_peri2dbus_s       gpio2dbus_o,
  input  logic                  gpio_sel_i,
  input  logic [GPIO_WIDTH-1:0] gpio_port_i,
  output logic [GPIO_WIDTH-1:0] gpio_port_o,
  output logic [GPIO_WIDTH-1:0] gpio_oe_o,
  output logic                  gpio_irq_o
);

  localparam int W = GPIO_WIDTH;

  localparam logic [2:0] REG_DATA_IN    = 3'd0;
  localparam logic [2:0] REG_DATA_OUT   = 3'd1;
  localparam logic [2:0] REG_DIR        = 3'd2;
  localparam logic [2:0] REG_OUT_SET    = 3'd3;
  localparam logic [2:0] REG_OUT_CLR    = 3'd4;
  localparam logic [2:0] REG_IRQ_EN     = 3'd5;
  localparam logic [2:0] REG_IRQ_POL    = 3'd6;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd7;

  logic [W-1:0] data_out;
  logic [W-1:0] dir;
  logic [W-1:0] irq_en;
  logic [W-1:0] irq_pol;
  logic [W-1:0] irq_status;
  logic [W-1:0] sync_q [SYNC_STAGES];
  logic [W-1:0] sync_in;
  logic [W-1:0] in_val;
  logic [W-1:0] prev_in;
  logic [W-1:0] hw_set;
  logic [W-1:0] w1c;
  logic [W-1:0] wmask;
  logic [W-1:0] wbits;
  logic [31:0]  bmask32;
  logic [31:0]  rd_val;
  logic [31:0]  rdata_q;
  logic         ack_q;
  logic         accept;
  logic         in_map;
  logic         wr_en;
  logic [2:0]   reg_idx;
  logic         unused_bits;

  // Bus decode. The register window covers offsets 0x00-0x1C; higher
  // offsets within addr[11:0] are unmapped.
  assign accept  = dbus2gpio_i.req && gpio_sel_i;
  assign in_map  = (dbus2gpio_i.addr[11:5] == 7'd0);
  assign reg_idx = dbus2gpio_i.addr[4:2];
  assign wr_en   = accept && dbus2gpio_i.wr && in_map;

  assign bmask32 = {{8{dbus2gpio_i.mask[3]}}, {8{dbus2gpio_i.mask[2]}},
                    {8{dbus2gpio_i.mask[1]}}, {8{dbus2gpio_i.mask[0]}}};
  assign wmask   = bmask32[W-1:0];
  assign wbits   = dbus2gpio_i.w_data[W-1:0] & wmask;

  assign unused_bits = ^{dbus2gpio_i.addr[31:12], dbus2gpio_i.addr[1:0],
                         dbus2gpio_i.w_data, bmask32};

  // Input synchroniser.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= gpio_port_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CNT_W-1:0] db_cnt [W];
  logic [W-1:0]     db_q;

  // The count tracks how many consecutive cycles sync_in has differed from
  // the filtered value. A single cycle of agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_q <= '0;
      for (int i = 0; i < W; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (sync_in[i] == db_q[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]   <= sync_in[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign in_val = db_q;
`else
  assign in_val = sync_in;
`endif

  // Edge detection runs on every pin regardless of DIR.
  // Changing the polarity only changes which edges are selected, so a
  // polarity change alone never creates an event.
  assign hw_set = (irq_pol & in_val & ~prev_in) | (~irq_pol & ~in_val & prev_in);

  always_comb begin
    w1c = '0;
    if (wr_en && reg_idx == REG_IRQ_STATUS) w1c = wbits;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_in    <= '0;
      data_out   <= '0;
      dir        <= '0;
      irq_en     <= '0;
      irq_pol    <= '0;
      irq_status <= '0;
    end else begin
      prev_in <= in_val;
      // A hardware set takes priority over a write-1-to-clear of the same bit.
      irq_status <= (irq_status & ~w1c) | hw_set;
      if (wr_en) begin
        case (reg_idx)
          REG_DATA_OUT: data_out <= (data_out & ~wmask) | wbits;
          REG_DIR:      dir      <= (dir & ~wmask) | wbits;
          REG_OUT_SET:  data_out <= data_out | wbits;
          REG_OUT_CLR:  data_out <= data_out & ~wbits;
          REG_IRQ_EN:   irq_en   <= (irq_en & ~wmask) | wbits;
          REG_IRQ_POL:  irq_pol  <= (irq_pol & ~wmask) | wbits;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (in_map) begin
      case (reg_idx)
        REG_DATA_IN:    rd_val = 32'(in_val);
        REG_DATA_OUT:   rd_val = 32'(data_out);
        REG_DIR:        rd_val = 32'(dir);
        REG_IRQ_EN:     rd_val = 32'(irq_en);
        REG_IRQ_POL:    rd_val = 32'(irq_pol);
        REG_IRQ_STATUS: rd_val = 32'(irq_status);
        default:        rd_val = '0;
      endcase
    end
  end

  // The response is registered. r_data stays 0 except in the ack cycle of a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q   <= accept;
      rdata_q <= (accept && !dbus2gpio_i.wr) ? rd_val : '0;
    end
  end

  assign gpio2dbus_o.r_data = rdata_q;
  assign gpio2dbus_o.ack    = ack_q;
  assign gpio_port_o        = data_out;
  assign gpio_oe_o          = dir;
  assign gpio_irq_o         = |(irq_status & irq_en);

endmodule

// File: tb/tb_gpio_ctrl.sv
module tb_gpio_ctrl;
  import dbus_pkg::*;

  localparam int W    = 16;
  localparam int SYNC = 2;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = SYNC + 16;
`else
  localparam int LAT = SYNC;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  type_dbus2peri_s dbus;
  type_peri2dbus_s resp;
  logic            sel;
  logic [W-1:0]    pins;
  logic [W-1:0]    port_o;
  logic [W-1:0]    oe_o;
  logic            irq_o;

  int          tests_run = 0;
  int          tests_failed = 0;
  logic        last_ack;
  logic [31:0] last_rdata;

  gpio_ctrl #(.GPIO_WIDTH(W), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dbus2gpio_i (dbus),
    .gpio2dbus_o (resp),
    .gpio_sel_i  (sel),
    .gpio_port_i (pins),
    .gpio_port_o (port_o),
    .gpio_oe_o   (oe_o),
    .gpio_irq_o  (irq_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One bus transfer. The request is driven on a negedge and accepted on the
  // next posedge. The response is sampled on the following negedge.
  task automatic bus_xfer(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    dbus.req = 1'b1; dbus.wr = wr; dbus.addr = addr;
    dbus.w_data = data; dbus.mask = mask; sel = 1'b1;
    @(negedge clk);
    dbus.req = 1'b0; dbus.wr = 1'b0; sel = 1'b0;
    last_ack   = resp.ack;
    last_rdata = resp.r_data;
  endtask

  task automatic test_reset();
    dbus = '0; sel = 1'b0; pins = '0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({resp.ack, port_o, oe_o, irq_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: ack=%0b port=%h oe=%h irq=%0b required all 0",
               resp.ack, port_o, oe_o, irq_o);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus_xfer(1'b0, 32'(i * 4), 32'h0, 4'h0);
      tests_run++;
      if (last_ack !== 1'b1 || last_rdata !== 32'h0) begin
        tests_failed++;
        $display("FAIL reset_read_%0h: ack=%0b rdata=%h required ack=1 rdata=0",
                 i * 4, last_ack, last_rdata);
      end
    end
    @(negedge clk);
    tests_run++;
    if (resp.ack !== 1'b0 || oe_o !== '0 || irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_idle: ack=%0b oe=%h irq=%0b required 0 0 0",
               resp.ack, oe_o, irq_o);
    end
  endtask

  task automatic test_outputs();
    bus_xfer(1'b1, 32'h08, 32'h00FF, 4'hF);
    tests_run++;
    if (oe_o !== 16'h00FF || last_ack !== 1'b1 || last_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL dir_write: oe=%h ack=%0b rdata=%h required 00ff 1 0",
               oe_o, last_ack, last_rdata);
    end
    bus_xfer(1'b1, 32'h04, 32'h00A5, 4'hF);
    tests_run++;
    if (port_o !== 16'h00A5) begin
      tests_failed++;
      $display("FAIL data_out_write: port=%h required 00a5", port_o);
    end
    bus_xfer(1'b1, 32'h0C, 32'h0002, 4'hF);
    tests_run++;
    if (port_o !== 16'h00A7) begin
      tests_failed++;
      $display("FAIL out_set: port=%h required 00a7", port_o);
    end
    bus_xfer(1'b1, 32'h10, 32'h0080, 4'hF);
    tests_run++;
    if (port_o !== 16'h0027) begin
      tests_failed++;
      $display("FAIL out_clr: port=%h required 0027", port_o);
    end
    bus_xfer(1'b0, 32'h04, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_0027) begin
      tests_failed++;
      $display("FAIL data_out_read: rdata=%h required 00000027", last_rdata);
    end
    bus_xfer(1'b0, 32'h0C, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0 || last_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL out_set_read: rdata=%h ack=%0b required 0 1", last_rdata, last_ack);
    end
  endtask

  task automatic test_mask();
    bus_xfer(1'b1, 32'h04, 32'h0000_1234, 4'b0001);
    bus_xfer(1'b0, 32'h04, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_0034) begin
      tests_failed++;
      $display("FAIL mask_data_out: rdata=%h required 00000034", last_rdata);
    end
    bus_xfer(1'b1, 32'h0C, 32'h0000_FF00, 4'b0001);
    tests_run++;
    if (port_o !== 16'h0034) begin
      tests_failed++;
      $display("FAIL mask_out_set: port=%h required 0034", port_o);
    end
    bus_xfer(1'b1, 32'h08, 32'hFFFF_FFFF, 4'hF);
    bus_xfer(1'b0, 32'h08, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_FFFF) begin
      tests_failed++;
      $display("FAIL dir_upper_bits: rdata=%h required 0000ffff", last_rdata);
    end
    bus_xfer(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF);
    bus_xfer(1'b0, 32'h20, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0 || last_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL unmapped_read: rdata=%h ack=%0b required 0 1", last_rdata, last_ack);
    end
    bus_xfer(1'b0, 32'h104, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL unmapped_alias_read: rdata=%h required 0", last_rdata);
    end
  endtask

  task automatic test_irq();
    bus_xfer(1'b1, 32'h14, 32'h0001, 4'hF);
    bus_xfer(1'b1, 32'h18, 32'h0001, 4'hF);
    @(negedge clk);
    pins[0] = 1'b1;
    repeat (LAT) @(negedge clk);
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_early: irq=%0b required 0 after %0d cycles", irq_o, LAT);
    end
    @(negedge clk);
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_rise: irq=%0b required 1 after %0d cycles", irq_o, LAT + 1);
    end
    bus_xfer(1'b0, 32'h1C, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL irq_status_read: rdata=%h required 00000001", last_rdata);
    end
    bus_xfer(1'b1, 32'h1C, 32'h0001, 4'hF);
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_w1c: irq=%0b required 0", irq_o);
    end
  endtask

  task automatic test_w1c_collision();
    bus_xfer(1'b1, 32'h18, 32'h0000, 4'hF);
    @(negedge clk);
    pins[3] = 1'b1;
    repeat (LAT + 3) @(negedge clk);
    bus_xfer(1'b0, 32'h1C, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL pol_falling_ignores_rise: status=%h required 0", last_rdata);
    end
    @(negedge clk);
    pins[3] = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    bus_xfer(1'b1, 32'h1C, 32'h0008, 4'hF);
    bus_xfer(1'b0, 32'h1C, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_0008) begin
      tests_failed++;
      $display("FAIL set_beats_w1c: status=%h required 00000008", last_rdata);
    end
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_gated_by_en: irq=%0b required 0", irq_o);
    end
    bus_xfer(1'b1, 32'h14, 32'h0008, 4'hF);
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_enable_late: irq=%0b required 1", irq_o);
    end
    bus_xfer(1'b1, 32'h1C, 32'h0008, 4'b0010);
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL w1c_masked: irq=%0b required 1", irq_o);
    end
    bus_xfer(1'b1, 32'h1C, 32'h0008, 4'b0001);
    tests_run++;
    if (irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL w1c_bit3: irq=%0b required 0", irq_o);
    end
  endtask

  task automatic test_data_in();
    @(negedge clk);
    pins = 16'h5A81;
    repeat (LAT - 2) @(negedge clk);
    bus_xfer(1'b0, 32'h00, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_0001) begin
      tests_failed++;
      $display("FAIL data_in_latency_old: rdata=%h required 00000001", last_rdata);
    end
    bus_xfer(1'b0, 32'h00, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_5A81) begin
      tests_failed++;
      $display("FAIL data_in_latency_new: rdata=%h required 00005a81", last_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    sel = 1'b1;
    dbus = '{req: 1'b1, wr: 1'b1, mask: 4'hF, addr: 32'h04, w_data: 32'h0011};
    @(negedge clk);
    dbus = '{req: 1'b1, wr: 1'b0, mask: 4'h0, addr: 32'h04, w_data: 32'h0};
    tests_run++;
    if (resp.ack !== 1'b1 || resp.r_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_wr1: ack=%0b rdata=%h required 1 0", resp.ack, resp.r_data);
    end
    @(negedge clk);
    dbus = '{req: 1'b1, wr: 1'b1, mask: 4'hF, addr: 32'h0C, w_data: 32'h0100};
    tests_run++;
    if (resp.ack !== 1'b1 || resp.r_data !== 32'h0000_0011) begin
      tests_failed++;
      $display("FAIL b2b_rd1: ack=%0b rdata=%h required 1 00000011", resp.ack, resp.r_data);
    end
    @(negedge clk);
    dbus = '{req: 1'b1, wr: 1'b0, mask: 4'h0, addr: 32'h04, w_data: 32'h0};
    tests_run++;
    if (resp.ack !== 1'b1 || resp.r_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_wr2: ack=%0b rdata=%h required 1 0", resp.ack, resp.r_data);
    end
    @(negedge clk);
    dbus = '0; sel = 1'b0;
    tests_run++;
    if (resp.ack !== 1'b1 || resp.r_data !== 32'h0000_0111) begin
      tests_failed++;
      $display("FAIL b2b_rd2: ack=%0b rdata=%h required 1 00000111", resp.ack, resp.r_data);
    end
    @(negedge clk);
    tests_run++;
    if (resp.ack !== 1'b0 || resp.r_data !== 32'h0) begin
      tests_failed++;
      $display("FAIL b2b_idle: ack=%0b rdata=%h required 0 0", resp.ack, resp.r_data);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    sel = 1'b1;
    dbus = '{req: 1'b1, wr: 1'b1, mask: 4'hF, addr: 32'h04, w_data: 32'hBEEF};
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    dbus = '0; sel = 1'b0; pins = '0;
    @(negedge clk);
    tests_run++;
    if (resp.ack !== 1'b0 || port_o !== '0 || oe_o !== '0 || irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid: ack=%0b port=%h oe=%h irq=%0b required all 0",
               resp.ack, port_o, oe_o, irq_o);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_xfer(1'b0, 32'h04, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0 || last_ack !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_mid_data_out: rdata=%h ack=%0b required 0 1", last_rdata, last_ack);
    end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce();
    bus_xfer(1'b1, 32'h18, 32'h0002, 4'hF);
    @(negedge clk);
    pins[1] = 1'b1;
    repeat (10) @(negedge clk);
    pins[1] = 1'b0;
    repeat (40) @(negedge clk);
    bus_xfer(1'b0, 32'h00, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL debounce_short_data_in: rdata=%h required 0", last_rdata);
    end
    bus_xfer(1'b0, 32'h1C, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL debounce_short_status: rdata=%h required 0", last_rdata);
    end
    @(negedge clk);
    pins[1] = 1'b1;
    repeat (LAT - 2) @(negedge clk);
    bus_xfer(1'b0, 32'h00, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0) begin
      tests_failed++;
      $display("FAIL debounce_long_early: rdata=%h required 0", last_rdata);
    end
    bus_xfer(1'b0, 32'h00, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_0002) begin
      tests_failed++;
      $display("FAIL debounce_long_data_in: rdata=%h required 00000002", last_rdata);
    end
    repeat (5) @(negedge clk);
    pins[1] = 1'b0;
    bus_xfer(1'b0, 32'h1C, 32'h0, 4'h0);
    tests_run++;
    if (last_rdata !== 32'h0000_0002) begin
      tests_failed++;
      $display("FAIL debounce_long_status: rdata=%h required 00000002", last_rdata);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_outputs();
    test_mask();
    test_irq();
    test_w1c_collision();
    test_data_in();
    test_back_to_back();
    test_reset_mid();
`ifdef GPIO_DEBOUNCE_EN
    test_debounce();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
